md_sched: RTL and testbench
===========================

# md_sched

Multiply/divide scheduler sitting beside the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from EX and sequences the shared fixed-latency multiplier and the multi-cycle divider (start/ready handshake). It owns the architectural HI/LO registers and raises a stall request that holds the pipeline until the result has committed.

## Interface
- MUL_LAT, 1: cycles between multiplier operands becoming valid and mul_result being valid (1..15).
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- op_valid  in  1  EX holds a multiply/divide-class op this cycle.
- op_type  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are ignored (no stall, no write).
- op_a, op_b  in  32 each  rs and rt operand values.
- flush  in  1  annul the op held in EX and any in-flight operation.
- stallreq  out  1  pipeline stall request to the stall controller.
- busy  out  1  state != IDLE.
- mul_signed  out  1; mul_ina, mul_inb  out  32 each; mul_result  in  64.
- div_start  out  1; div_signed  out  1; div_opdata1, div_opdata2  out  32 each; div_annul  out  1; div_result  in  64 ({remainder, quotient}); div_ready  in  1.
- hi, lo  out  32 each  architectural HI/LO registers.

## Operation
- Reset (resetn=0, async): state IDLE, hi=lo=0, operand latches 0, counter 0. All outputs are 0 during reset.
- Operand latches opa_r, opb_r and signed_r drive mul_ina/mul_inb/mul_signed and div_opdata1/div_opdata2/div_signed at all times.
- FSM states: IDLE, MUL_WAIT, DIV_RUN, DONE.
- IDLE:
  - op_valid & MULT/MULTU & !flush: latch op_a/op_b/signed, cnt=MUL_LAT, go MUL_WAIT.
  - op_valid & DIV/DIVU & !flush: latch operands, go DIV_RUN.
  - op_valid & MTHI/MTLO & !flush: write hi or lo = op_a at the edge; stay IDLE; no stall.
- MUL_WAIT:
  - cnt decrements each cycle.
  - In the cycle cnt==1: {hi,lo} <= mul_result at the edge, go DONE.
- DIV_RUN:
  - div_start=1.
  - When div_ready=1: hi <= div_result[63:32], lo <= div_result[31:0], go DONE; div_start drops in DONE.
  - Divide-by-zero handling belongs to the divider; its result is written unchanged.
- DONE: always go IDLE. op_valid in DONE is the same held op and is never re-accepted.
- stallreq = !flush & ((IDLE & op_valid & op_type∈{MULT,MULTU,DIV,DIVU}) | MUL_WAIT | DIV_RUN). It is 0 in DONE.
- flush (any state): next state IDLE; no HI/LO write that edge, flush wins over a simultaneous capture; div_annul = flush & DIV_RUN; stallreq=0.
- op_valid/op_type changes outside IDLE are ignored. The pipeline is stalled, so they must not occur.
- mul_result and div_result are captured only at the points defined above. HI/LO are never written speculatively.

## Timing
- MULT/MULTU: accept cycle (stall) + MUL_LAT MUL_WAIT cycles (stall) + DONE (no stall).
  - EX occupancy is MUL_LAT+2 cycles; stallreq is high for MUL_LAT+1 cycles.
  - New hi/lo are visible from the first DONE cycle.
- DIV/DIVU: accept cycle + DIV_RUN until div_ready + DONE.
  - stallreq is high from the accept cycle through the div_ready cycle inclusive.
- MTHI/MTLO: single cycle; value visible on hi/lo the next cycle.
- Back-to-back ops: a new op can be accepted in the cycle after DONE, with no bubble added by this block.
- Async reset mid-operation: immediate return to IDLE, hi=lo=0, div_start=0. The divider is reset by the same resetn.

## Test plan
- Reset then MTHI op_a=0x12345678, next cycle MTLO op_a=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, stallreq never 1.
- MULT with MUL_LAT=1, op_a=0xFFFFFFFE (-2), op_b=3 -> stallreq high 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA in DONE.
- MULTU with op_a=op_b=0xFFFFFFFF -> mul_signed=0, hi=0xFFFFFFFE, lo=0x00000001.
- DIV with op_a=-7 (0xFFFFFFF9), op_b=2; model div_ready after 33 cycles with result {0xFFFFFFFF, 0xFFFFFFFD} -> div_start/div_signed=1 throughout DIV_RUN, stallreq drops in DONE, hi=0xFFFFFFFF, lo=0xFFFFFFFD.
- DIVU in flight, flush asserted in the same cycle as div_ready=1 -> div_annul=1, hi/lo unchanged, state IDLE next cycle, stallreq=0.
- Assert resetn=0 mid-DIV_RUN between clock edges -> hi=lo=0, div_start=0, busy=0 immediately (asynchronous); after release, MULTU 5×7 -> lo=35, hi=0.

Source files
------------

// File: rtl/md_sched_if.sv
// md_sched_if: EX-side op bus, multiplier/divider handshake and HI/LO outputs of the multiply/divide scheduler
interface md_sched_if;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stallreq;
  logic        busy;
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  modport slave (
    input  op_valid, op_type, op_a, op_b, flush, mul_result, div_result, div_ready,
    output stallreq, busy, mul_signed, mul_ina, mul_inb, div_start, div_signed,
           div_opdata1, div_opdata2, div_annul, hi, lo
  );
  modport master (
    output op_valid, op_type, op_a, op_b, flush, mul_result, div_result, div_ready,
    input  stallreq, busy, mul_signed, mul_ina, mul_inb, div_start, div_signed,
           div_opdata1, div_opdata2, div_annul, hi, lo
  );
endinterface

// File: rtl/md_sched.sv
// md_sched: sequences the shared multiplier and divider for MULT/DIV-class ops and owns HI/LO
module md_sched #(
  parameter int unsigned MUL_LAT = 1
) (
  input logic       clk,
  input logic       resetn,
  md_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, opa_q, opa_d, opb_q, opb_d;
  logic        signed_q, signed_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_md;
  assign is_md = !bus.op_type[2];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
    end
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    signed_d = signed_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE:
        if (bus.op_valid && !bus.flush) begin
          if (is_md) begin
            opa_d    = bus.op_a;
            opb_d    = bus.op_b;
            signed_d = !bus.op_type[0];
            cnt_d    = 4'(MUL_LAT);
            state_d  = bus.op_type[1] ? DIV_RUN : MUL_WAIT;
          end else if (bus.op_type == 3'b100) hi_d = bus.op_a;
          else if (bus.op_type == 3'b101) lo_d = bus.op_a;
        end
      MUL_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          {hi_d, lo_d} = bus.mul_result;
          state_d      = DONE;
        end
      end
      DIV_RUN:
        if (bus.div_ready) begin
          {hi_d, lo_d} = bus.div_result;
          state_d      = DONE;
        end
      default: state_d = IDLE;
    endcase
    // flush beats any capture happening on the same edge
    if (bus.flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end
  assign bus.busy        = state_q != IDLE;
  assign bus.div_start   = state_q == DIV_RUN;
  assign bus.div_annul   = bus.flush && state_q == DIV_RUN;
  assign bus.stallreq    = resetn && !bus.flush &&
                           ((state_q == IDLE && bus.op_valid && is_md) || state_q == MUL_WAIT || state_q == DIV_RUN);
  assign bus.mul_signed  = signed_q;
  assign bus.mul_ina     = opa_q;
  assign bus.mul_inb     = opb_q;
  assign bus.div_signed  = signed_q;
  assign bus.div_opdata1 = opa_q;
  assign bus.div_opdata2 = opb_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed scoreboard bench for md_sched with behavioural multiplier and divider models
module tb_md_sched;
  localparam int unsigned LAT = 1;
  logic clk, resetn;
  int vectors, miscompares;
  logic [63:0] sb[$];
  logic [5:0] dcnt;
  logic signed [63:0] sa, sb_ext;
  md_sched_if bus();
  md_sched #(.MUL_LAT(LAT)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always_comb begin
    sa     = {{32{bus.mul_ina[31] & bus.mul_signed}}, bus.mul_ina};
    sb_ext = {{32{bus.mul_inb[31] & bus.mul_signed}}, bus.mul_inb};
    bus.mul_result = 64'(sa * sb_ext);
  end
  always @(posedge clk or negedge resetn)
    if (!resetn) dcnt <= '0;
    else dcnt <= (bus.div_start && !bus.div_ready) ? dcnt + 6'd1 : 6'd0;
  assign bus.div_ready = bus.div_start && dcnt == 6'd32;
  always_comb begin
    if (bus.div_opdata2 == 32'd0) bus.div_result = '1;
    else if (bus.div_signed)
      bus.div_result = {32'($signed(bus.div_opdata1) % $signed(bus.div_opdata2)),
                        32'($signed(bus.div_opdata1) / $signed(bus.div_opdata2))};
    else bus.div_result = {bus.div_opdata1 % bus.div_opdata2, bus.div_opdata1 / bus.div_opdata2};
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_stall);
    int stalls = 0;
    int bad_start = 0;
    bit done = 0;
    logic [63:0] e;
    sb.push_back(exp);
    bus.op_valid = 1'b1;
    bus.op_type  = t;
    bus.op_a     = a;
    bus.op_b     = b;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (bus.busy && !bus.stallreq) begin
        done = 1;
        e = sb.pop_front();
        check("hilo", {bus.hi, bus.lo}, e);
        check("mul_signed", 64'(bus.mul_signed), 64'(!t[0]));
        check("div_signed", 64'(bus.div_signed), 64'(!t[0]));
      end else begin
        if (bus.stallreq) stalls++;
        if (bus.busy && bus.div_start !== t[1]) bad_start++;
        @(negedge clk);
      end
    end
    check("done_seen", 64'(done), 64'd1);
    check("stall_cycles", 64'(stalls), 64'(exp_stall));
    check("div_start_level", 64'(bad_start), 64'd0);
    @(negedge clk);
  endtask
  initial begin
    vectors = 0;
    miscompares = 0;
    resetn = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_type = 3'b000;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.flush = 1'b0;
    #12;
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_ctrl", {61'd0, bus.stallreq, bus.busy, bus.div_start}, 64'd0);
    check("rst_opnds", {bus.mul_ina, bus.div_opdata2}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_type = 3'b100; bus.op_a = 32'h12345678;
    #1 check("mthi_stall", 64'(bus.stallreq), 64'd0);
    @(negedge clk);
    check("mthi_hi", 64'(bus.hi), 64'h12345678);
    bus.op_type = 3'b101; bus.op_a = 32'h9ABCDEF0;
    #1 check("mtlo_stall", 64'(bus.stallreq), 64'd0);
    @(negedge clk);
    check("mtlo_hilo", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);
    bus.op_type = 3'b100; bus.op_a = 32'hFFFF0000; bus.flush = 1'b1;
    @(negedge clk);
    check("mthi_flushed", 64'(bus.hi), 64'h12345678);
    bus.flush = 1'b0; bus.op_type = 3'b110; bus.op_a = 32'hDEADBEEF;
    #1 check("illegal_stall", 64'(bus.stallreq), 64'd0);
    @(negedge clk);
    check("illegal_state", {bus.hi, bus.lo, 31'd0, bus.busy}, {64'h12345678_9ABCDEF0, 32'd0});
    run_op(3'b000, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, LAT + 1);
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, LAT + 1);
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
    bus.op_valid = 1'b1; bus.op_type = 3'b011; bus.op_a = 32'd100; bus.op_b = 32'd7;
    for (int i = 0; i < 100 && !bus.div_ready; i++) @(negedge clk);
    check("flush_ready_seen", 64'(bus.div_ready), 64'd1);
    bus.flush = 1'b1; bus.op_valid = 1'b0;
    #1;
    check("flush_annul", 64'(bus.div_annul), 64'd1);
    check("flush_stall", 64'(bus.stallreq), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_idle", {63'd0, bus.busy}, 64'd0);
    check("flush_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_type = 3'b010; bus.op_a = 32'd50; bus.op_b = 32'd3;
    repeat (5) @(negedge clk);
    check("pre_rst_divrun", {62'd0, bus.busy, bus.div_start}, 64'd3);
    #2 resetn = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    check("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("async_rst_ctrl", {62'd0, bus.busy, bus.div_start}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op(3'b001, 32'd5, 32'd7, 64'd35, LAT + 1);
    run_op(3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, LAT + 1);
    run_op(3'b011, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
